// File: rtl/instr_mem.sv
// 1024 x 32 instruction memory: synchronous write on every edge, asynchronous read,
// and a synchronous whole-array clear that takes priority over the write.
module instr_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] addr_w,
  input  logic [ADDR_W-1:0] addr_r,
  output logic [DATA_W-1:0] data_out
);

  // Flop/LUT storage; the single-cycle whole-array clear rules out block RAM.
  logic [DATA_W-1:0] mem [DEPTH];

  // No write enable: the loader repeats its last write when idle.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      mem[addr_w] <= data_in;
    end
  end

  assign data_out = mem[addr_r];

endmodule

// File: tb/tb_instr_mem.sv
// Self-checking bench for instr_mem: directed steps from the test plan followed by
// randomized writes/clears checked against an array-based reference model.
module tb_instr_mem;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk;
  logic              clr;
  logic [DATA_W-1:0] data_in;
  logic [ADDR_W-1:0] addr_w;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] data_out;

  int total;
  int bad;

  logic [DATA_W-1:0] ref_mem [DEPTH];

  instr_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .data_in (data_in),
    .addr_w  (addr_w),
    .addr_r  (addr_r),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what every rising edge does to the array, straight from the rules.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] <= '0;
    end else begin
      ref_mem[addr_w] <= data_in;
    end
  end

  // Inputs change on the falling edge so they are stable well before the next rising edge.
  task automatic applyStimulus(input logic c, input logic [ADDR_W-1:0] aw,
                               input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] ar);
    @(negedge clk);
    clr     = c;
    addr_w  = aw;
    data_in = d;
    addr_r  = ar;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] expected);
    total++;
    assert (data_out === expected) else begin
      bad++;
      $error("[TB] FAIL %s: addr_r=%0d observed=%h expected=%h", tag, addr_r, data_out, expected);
    end
  endtask

  initial begin
    logic              c;
    logic [ADDR_W-1:0] aw;
    logic [ADDR_W-1:0] ar;
    logic [DATA_W-1:0] d;

    total   = 0;
    bad     = 0;
    clr     = 1'b1;
    addr_w  = '0;
    addr_r  = '0;
    data_in = '0;

    // Clear, then sweep every address with clr still high so no edge can write.
    applyStimulus(1'b1, 10'd0, 32'h0, 10'd0);
    step();
    for (int a = 0; a < DEPTH; a++) begin
      addr_r = ADDR_W'(a);
      #2;
      checkOutput("clear_sweep", 32'h0000_0000);
    end

    // Sequential writes on consecutive edges, then readback one address per cycle.
    applyStimulus(1'b0, 10'd0, 32'hAAAA_BBBB, 10'd0);
    step();
    applyStimulus(1'b0, 10'd1, 32'h1234_5678, 10'd0);
    step();
    applyStimulus(1'b0, 10'd2, 32'hDEAD_BEEF, 10'd0);
    step();
    applyStimulus(1'b0, 10'd2, 32'hDEAD_BEEF, 10'd0);
    step();
    checkOutput("seq_rd0", 32'hAAAA_BBBB);
    applyStimulus(1'b0, 10'd2, 32'hDEAD_BEEF, 10'd1);
    step();
    checkOutput("seq_rd1", 32'h1234_5678);
    applyStimulus(1'b0, 10'd2, 32'hDEAD_BEEF, 10'd2);
    step();
    checkOutput("seq_rd2", 32'hDEAD_BEEF);

    // Overwrite word 1, then move the read address onto it.
    applyStimulus(1'b0, 10'd1, 32'hFFFF_0000, 10'd2);
    step();
    checkOutput("ovw_other", 32'hDEAD_BEEF);
    applyStimulus(1'b0, 10'd1, 32'hFFFF_0000, 10'd1);
    step();
    checkOutput("ovw_rd1", 32'hFFFF_0000);

    // Read-during-write at the same address: old word before the edge, new word after.
    applyStimulus(1'b0, 10'd5, 32'h1111_1111, 10'd5);
    step();
    checkOutput("rdw_init", 32'h1111_1111);
    applyStimulus(1'b0, 10'd5, 32'h2222_2222, 10'd5);
    #1;
    checkOutput("rdw_before", 32'h1111_1111);
    step();
    checkOutput("rdw_after", 32'h2222_2222);

    // Clear wins over the write on the same edge; the write lands on the next clr=0 edge.
    applyStimulus(1'b1, 10'd3, 32'hCAFE_F00D, 10'd3);
    step();
    checkOutput("clrpri_w3", 32'h0000_0000);
    addr_r = 10'd5;
    #2;
    checkOutput("clrpri_w5", 32'h0000_0000);
    applyStimulus(1'b0, 10'd3, 32'hCAFE_F00D, 10'd3);
    step();
    checkOutput("clrpri_after", 32'hCAFE_F00D);

    // Boundary addresses must not alias each other.
    applyStimulus(1'b0, 10'd1023, 32'h0BAD_F00D, 10'd1023);
    step();
    checkOutput("bnd_1023", 32'h0BAD_F00D);
    applyStimulus(1'b0, 10'd0, 32'h600D_CAFE, 10'd0);
    step();
    checkOutput("bnd_0", 32'h600D_CAFE);
    applyStimulus(1'b0, 10'd0, 32'h600D_CAFE, 10'd1023);
    step();
    checkOutput("bnd_1023_again", 32'h0BAD_F00D);

    // Random writes and occasional clears, mostly in a small window so readbacks hit data.
    for (int n = 0; n < 400; n++) begin
      c  = ($urandom_range(0, 31) == 0);
      aw = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
      d  = $urandom;
      ar = ($urandom_range(0, 3) == 0) ? aw : ADDR_W'($urandom_range(0, 15));
      applyStimulus(c, aw, d, ar);
      #1;
      checkOutput("rand_pre", ref_mem[addr_r]);
      step();
      checkOutput("rand_post", ref_mem[addr_r]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
